// File: rtl/fetch_pc_unit_if.sv
// Signal bundle between the fetch unit and its neighbours: instruction memory,
// the IF/ID valid/ready handshake toward decode, and the redirect from later stages.
interface fetch_pc_unit_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_instr;
   logic              if_valid;
   logic [31:0]       if_instr;
   logic [31:0]       if_pc;
   logic              id_ready;
   logic              redirect_valid;
   logic [31:0]       redirect_target;

   modport master (
      output imem_addr,
      input  imem_instr,
      output if_valid, if_instr, if_pc,
      input  id_ready,
      input  redirect_valid, redirect_target
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      input  if_valid, if_instr, if_pc,
      output id_ready,
      output redirect_valid, redirect_target
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, predecodes j/jal for zero-bubble jumps,
// and holds the fetched instruction in an IF/ID register with a valid/ready handshake.
module fetch_pc_unit #(
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fetch_pc_unit_if.master        bus,
   output logic [31:0]            pc,
   output logic                   pc_oob,
   output logic                   err_misaligned,
   output logic [15:0]            stall_cycles
);

   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [5:0]  opcode;
   logic        is_jump;
   logic        fire;
   logic        stalled;

   always_comb begin
      pc_plus4 = pc + 32'd4;
      opcode   = bus.imem_instr[31:26];
      is_jump  = (opcode == 6'b000010) || (opcode == 6'b000011);
      // Jump target is resolved here so the next fetch already follows the jump.
      next_pc  = is_jump ? {pc_plus4[31:28], bus.imem_instr[25:0], 2'b00} : pc_plus4;
      fire     = !bus.if_valid || bus.id_ready;
      stalled  = bus.if_valid && !bus.id_ready && !bus.redirect_valid;
   end

   assign bus.imem_addr = pc[ADDR_W+1:2];
   assign pc_oob        = |pc[31:ADDR_W+2];

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         bus.if_valid <= 1'b0;
         bus.if_instr <= 32'h0;
         bus.if_pc    <= 32'h0;
      end else if (bus.redirect_valid) begin
         pc           <= {bus.redirect_target[31:2], 2'b00};
         bus.if_valid <= 1'b0;
      end else if (fire) begin
         pc           <= next_pc;
         bus.if_valid <= 1'b1;
         bus.if_instr <= bus.imem_instr;
         bus.if_pc    <= pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_misaligned <= 1'b0;
         stall_cycles   <= 16'h0;
      end else begin
         if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00))
            err_misaligned <= 1'b1;
         if (stalled && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end that owns the program counter and drives the word address of the 64-entry instruction memory. It captures the returned instruction into an IF/ID output register with a valid/ready handshake toward decode. Jumps (j/jal) are predecoded in fetch so they take no bubble, and branch redirects from later stages are accepted with flush. A saturating stall counter is included for performance checks.

## Interface
- ADDR_W, 6: instruction-memory word-address width (64 words)
- RESET_PC, 32'h0000_0000: PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  word address to instruction memory, = pc[ADDR_W+1:2]
- imem_instr  in  32  instruction returned combinationally for imem_addr
- pc  out  32  current fetch PC
- pc_oob  out  1  combinational, = |pc[31:ADDR_W+2] (PC beyond memory range)
- if_valid  out  1  IF/ID register holds a valid instruction
- if_instr  out  32  captured instruction
- if_pc  out  32  PC of captured instruction
- id_ready  in  1  decode accepts if_instr this cycle
- redirect_valid  in  1  branch/exception redirect from a later stage
- redirect_target  in  32  redirect byte address
- err_misaligned  out  1  sticky, set when a redirect_target has nonzero [1:0]
- stall_cycles  out  16  count of cycles with if_valid=1 and id_ready=0, saturating

## Operation
- Reset (async, rst_n=0): pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, err_misaligned=0, stall_cycles=0.
- fire = !if_valid || id_ready, meaning the output register can take a new instruction.
- Priority, evaluated each rising edge:
  1. redirect_valid=1: pc <= {redirect_target[31:2],2'b00}; if_valid <= 0 (flush, even if id_ready=0); no capture. If redirect_target[1:0]!=0, err_misaligned <= 1.
  2. Else if fire: if_instr <= imem_instr; if_pc <= pc; if_valid <= 1; pc <= next_pc.
  3. Else (stall): pc, if_valid, if_instr and if_pc hold.
- next_pc: if imem_instr[31:26] is 6'b000010 (j) or 6'b000011 (jal), next_pc = {pc_plus4[31:28], imem_instr[25:0], 2'b00}. Otherwise next_pc = pc + 4. No delay slot.
- pc + 4 is modulo 2^32 (0xFFFF_FFFC wraps to 0).
- imem_addr is bits [ADDR_W+1:2] only, so addresses alias beyond 4*2^ADDR_W bytes. Fetch continues while aliased and pc_oob flags it.
- stall_cycles increments on each edge where if_valid && !id_ready && !redirect_valid, and holds at 16'hFFFF.
- err_misaligned is cleared only by reset.

## Timing
- imem_addr follows pc combinationally. The instruction is sampled at the same edge that advances pc.
- Fetch latency: instruction at pc appears on if_instr with if_valid=1 one cycle after pc is presented.
- Sustained throughput is 1 instruction/cycle while id_ready=1, including across jumps (zero bubble).
- Redirect at edge N: pc=target and if_valid=0 after N, and the target instruction is valid after N+1. This gives one bubble.
- Redirect and jump predecode in the same cycle: redirect wins.
- Redirect while stalled: the held instruction is discarded and the stall ends.
- Handshake: the instruction transfers on an edge with if_valid && id_ready. if_instr and if_pc must stay stable while if_valid && !id_ready.
- Reset asserted mid-stream: all outputs return to reset values immediately (async) and fetch restarts at RESET_PC on the first edge after release.

## Test plan
- Sequential fetch: reset release, id_ready=1, memory words 0..2 = 8c080100, 01084820, 212a0002 → successive (if_pc, if_instr) = (0,8c080100), (4,01084820), (8,212a0002), if_valid=1 from the first edge.
- Stall: id_ready=0 for 3 cycles with if_pc=0x8 → if_instr/if_pc/pc frozen, stall_cycles=3. id_ready=1 → resumes at 0xC with no loss or duplicate.
- Jump predecode: word 19 = 08000015 at pc=0x4C → next if_pc=0x4C, then 0x54 with word 21 (01085020), no bubble.
- Redirect: redirect_valid=1 with target 0x40 while stalled → if_valid=0 next cycle, then if_pc=0x40. With redirect and jump in the same cycle, the redirect target is used.
- Misaligned/wrap: target 0x23 → pc=0x20, err_misaligned=1 (sticky). Target 0x100 → imem_addr=0, pc_oob=1. Target 0xFFFFFFFC (non-jump) → pc wraps to 0, pc_oob clears.
- Reset mid-op: assert rst_n=0 during a stall, between edges → if_valid=0, pc=RESET_PC, stall_cycles=0 immediately. After release, fetch resumes at word 0.
